// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Purpose  : Shared types, defaults and grant selection for the SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int c_ADDR_W           = 24;
    localparam int c_DATA_W           = 16;
    localparam int c_REFRESH_INTERVAL = 374;

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GR_CPU = 2'd0,
        GR_LDR = 2'd1,
        GR_REF = 2'd2
    } grant_t;

    // Refresh always wins; a tie between requesters goes to the one not served last.
    function automatic grant_t pick_grant(
        input logic   refresh_pending,
        input logic   cpu_req,
        input logic   ldr_req,
        input grant_t last_grant
    );
        if (refresh_pending) begin
            return GR_REF;
        end
        if (cpu_req && ldr_req) begin
            return (last_grant == GR_CPU) ? GR_LDR : GR_CPU;
        end
        if (ldr_req) begin
            return GR_LDR;
        end
        return GR_CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_refresh_timer
// Purpose  : Periodic refresh request generator with a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = c_REFRESH_INTERVAL
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_take,
    output logic o_refresh_pending,
    output logic o_refresh_overrun
);

    localparam int                 c_CNT_W  = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic               r_pending_q;
    logic               w_pending_d;
    logic               r_overrun_q;
    logic               w_overrun_d;

    // A new expiry outranks a same-cycle take, so the fresh request is never lost.
    always_comb begin
        w_count_d   = r_count_q;
        w_pending_d = r_pending_q;
        w_overrun_d = r_overrun_q;
        if (i_take) begin
            w_pending_d = 1'b0;
        end
        if (!i_enable) begin
            w_count_d = c_RELOAD;
        end else if (r_count_q == '0) begin
            w_count_d   = c_RELOAD;
            w_pending_d = 1'b1;
            if (r_pending_q) begin
                w_overrun_d = 1'b1;
            end
        end else begin
            w_count_d = r_count_q - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q   <= c_RELOAD;
            r_pending_q <= 1'b0;
            r_overrun_q <= 1'b0;
        end else begin
            r_count_q   <= w_count_d;
            r_pending_q <= w_pending_d;
            r_overrun_q <= w_overrun_d;
        end
    end

    assign o_refresh_pending = r_pending_q;
    assign o_refresh_overrun = r_overrun_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Shares the SDRAM command core between CPU and loader, with refresh.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W           = c_ADDR_W,
    parameter int DATA_W           = c_DATA_W,
    parameter int REFRESH_INTERVAL = c_REFRESH_INTERVAL
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic [1:0]        ldr_be,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ctl_req,
    output logic              ctl_refresh,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic [1:0]        ctl_dm,
    input  logic              ctl_ack,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_init_done,
    output logic              refresh_overrun
);

    state_t              r_state_q,       w_state_d;
    grant_t              r_grant_q,       w_grant_d;
    grant_t              r_last_grant_q,  w_last_grant_d;
    logic                r_ctl_req_q,     w_ctl_req_d;
    logic                r_ctl_refresh_q, w_ctl_refresh_d;
    logic                r_ctl_we_q,      w_ctl_we_d;
    logic [ADDR_W-1:0]   r_ctl_addr_q,    w_ctl_addr_d;
    logic [DATA_W-1:0]   r_ctl_wdata_q,   w_ctl_wdata_d;
    logic [1:0]          r_ctl_dm_q,      w_ctl_dm_d;
    logic                r_cpu_ack_q,     w_cpu_ack_d;
    logic [DATA_W-1:0]   r_cpu_rdata_q,   w_cpu_rdata_d;
    logic                r_ldr_ack_q,     w_ldr_ack_d;
    logic [DATA_W-1:0]   r_ldr_rdata_q,   w_ldr_rdata_d;
    grant_t              w_sel;
    logic                w_take;
    logic                w_refresh_pending;
    logic                w_refresh_overrun;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk               (clk_48mhz),
        .rst               (reset),
        .i_enable          (ctl_init_done),
        .i_take            (w_take),
        .o_refresh_pending (w_refresh_pending),
        .o_refresh_overrun (w_refresh_overrun)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_grant_d       = r_grant_q;
        w_last_grant_d  = r_last_grant_q;
        w_ctl_req_d     = r_ctl_req_q;
        w_ctl_refresh_d = r_ctl_refresh_q;
        w_ctl_we_d      = r_ctl_we_q;
        w_ctl_addr_d    = r_ctl_addr_q;
        w_ctl_wdata_d   = r_ctl_wdata_q;
        w_ctl_dm_d      = r_ctl_dm_q;
        w_cpu_ack_d     = 1'b0;
        w_cpu_rdata_d   = r_cpu_rdata_q;
        w_ldr_ack_d     = 1'b0;
        w_ldr_rdata_d   = r_ldr_rdata_q;
        w_take          = 1'b0;
        w_sel           = pick_grant(w_refresh_pending, cpu_req, ldr_req, r_last_grant_q);

        case (r_state_q)
            INIT_WAIT: begin
                if (ctl_init_done) begin
                    w_state_d = IDLE;
                end
            end
            IDLE: begin
                if (w_refresh_pending || cpu_req || ldr_req) begin
                    w_state_d       = ISSUE;
                    w_grant_d       = w_sel;
                    w_ctl_req_d     = 1'b1;
                    w_ctl_refresh_d = (w_sel == GR_REF);
                    case (w_sel)
                        GR_CPU: begin
                            w_ctl_we_d     = cpu_we;
                            w_ctl_addr_d   = cpu_addr;
                            w_ctl_wdata_d  = cpu_wdata;
                            w_ctl_dm_d     = ~cpu_be;
                            w_last_grant_d = GR_CPU;
                        end
                        GR_LDR: begin
                            w_ctl_we_d     = ldr_we;
                            w_ctl_addr_d   = ldr_addr;
                            w_ctl_wdata_d  = ldr_wdata;
                            w_ctl_dm_d     = ~ldr_be;
                            w_last_grant_d = GR_LDR;
                        end
                        default: begin
                            w_ctl_we_d = 1'b0;
                            w_take     = 1'b1;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (ctl_ack) begin
                    w_state_d       = DONE;
                    w_ctl_req_d     = 1'b0;
                    w_ctl_refresh_d = 1'b0;
                    case (r_grant_q)
                        GR_CPU: begin
                            w_cpu_ack_d   = 1'b1;
                            w_cpu_rdata_d = ctl_rdata;
                        end
                        GR_LDR: begin
                            w_ldr_ack_d   = 1'b1;
                            w_ldr_rdata_d = ctl_rdata;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            // One dead cycle lets the served requester drop its req before IDLE samples it.
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state_q       <= INIT_WAIT;
            r_grant_q       <= GR_CPU;
            r_last_grant_q  <= GR_LDR;
            r_ctl_req_q     <= 1'b0;
            r_ctl_refresh_q <= 1'b0;
            r_ctl_we_q      <= 1'b0;
            r_ctl_addr_q    <= '0;
            r_ctl_wdata_q   <= '0;
            r_ctl_dm_q      <= 2'b11;
            r_cpu_ack_q     <= 1'b0;
            r_cpu_rdata_q   <= '0;
            r_ldr_ack_q     <= 1'b0;
            r_ldr_rdata_q   <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_grant_q       <= w_grant_d;
            r_last_grant_q  <= w_last_grant_d;
            r_ctl_req_q     <= w_ctl_req_d;
            r_ctl_refresh_q <= w_ctl_refresh_d;
            r_ctl_we_q      <= w_ctl_we_d;
            r_ctl_addr_q    <= w_ctl_addr_d;
            r_ctl_wdata_q   <= w_ctl_wdata_d;
            r_ctl_dm_q      <= w_ctl_dm_d;
            r_cpu_ack_q     <= w_cpu_ack_d;
            r_cpu_rdata_q   <= w_cpu_rdata_d;
            r_ldr_ack_q     <= w_ldr_ack_d;
            r_ldr_rdata_q   <= w_ldr_rdata_d;
        end
    end

    assign ctl_req         = r_ctl_req_q;
    assign ctl_refresh     = r_ctl_refresh_q;
    assign ctl_we          = r_ctl_we_q;
    assign ctl_addr        = r_ctl_addr_q;
    assign ctl_wdata       = r_ctl_wdata_q;
    assign ctl_dm          = r_ctl_dm_q;
    assign cpu_ack         = r_cpu_ack_q;
    assign cpu_rdata       = r_cpu_rdata_q;
    assign ldr_ack         = r_ldr_ack_q;
    assign ldr_rdata       = r_ldr_rdata_q;
    assign refresh_overrun = w_refresh_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter with a behavioural core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int c_AW  = 24;
    localparam int c_DW  = 16;
    localparam int c_REF = 16;

    logic            clk_48mhz = 1'b0;
    logic            reset     = 1'b1;
    logic            cpu_req = 1'b0, cpu_we = 1'b0;
    logic [c_AW-1:0] cpu_addr = '0;
    logic [c_DW-1:0] cpu_wdata = '0;
    logic [1:0]      cpu_be = 2'b11;
    logic            cpu_ack;
    logic [c_DW-1:0] cpu_rdata;
    logic            ldr_req = 1'b0, ldr_we = 1'b0;
    logic [c_AW-1:0] ldr_addr = '0;
    logic [c_DW-1:0] ldr_wdata = '0;
    logic [1:0]      ldr_be = 2'b11;
    logic            ldr_ack;
    logic [c_DW-1:0] ldr_rdata;
    logic            ctl_req, ctl_refresh, ctl_we;
    logic [c_AW-1:0] ctl_addr;
    logic [c_DW-1:0] ctl_wdata;
    logic [1:0]      ctl_dm;
    logic            ctl_ack = 1'b0;
    logic [c_DW-1:0] ctl_rdata = '0;
    logic            ctl_init_done = 1'b0;
    logic            refresh_overrun;

    always #5 clk_48mhz = ~clk_48mhz;

    sdram_arbiter #(
        .ADDR_W           (c_AW),
        .DATA_W           (c_DW),
        .REFRESH_INTERVAL (c_REF)
    ) dut (
        .clk_48mhz       (clk_48mhz),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_be          (cpu_be),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .ldr_req         (ldr_req),
        .ldr_we          (ldr_we),
        .ldr_addr        (ldr_addr),
        .ldr_wdata       (ldr_wdata),
        .ldr_be          (ldr_be),
        .ldr_ack         (ldr_ack),
        .ldr_rdata       (ldr_rdata),
        .ctl_req         (ctl_req),
        .ctl_refresh     (ctl_refresh),
        .ctl_we          (ctl_we),
        .ctl_addr        (ctl_addr),
        .ctl_wdata       (ctl_wdata),
        .ctl_dm          (ctl_dm),
        .ctl_ack         (ctl_ack),
        .ctl_rdata       (ctl_rdata),
        .ctl_init_done   (ctl_init_done),
        .refresh_overrun (refresh_overrun)
    );

    typedef struct {
        logic            we;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] wdata;
        logic [1:0]      dm;
    } cmd_t;

    typedef struct {
        logic            is_ldr;
        logic            we;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] wdata;
        logic [1:0]      be;
        logic [c_DW-1:0] core_rdata;
        logic [1:0]      exp_dm;
    } vec_t;

    typedef struct {
        logic            refresh;
        logic [c_AW-1:0] addr;
    } log_t;

    cmd_t            exp_cmd_q[$];
    logic [c_DW-1:0] exp_cpu_q[$];
    logic [c_DW-1:0] exp_ldr_q[$];
    log_t            cmd_log[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    int              core_lat      = 2;
    logic            core_force_en = 1'b0;
    logic [c_DW-1:0] core_force_val = '0;
    logic            inject_ack    = 1'b0;
    int              core_cnt      = 0;
    int              core_cur_lat  = 2;
    logic            mon_prev_req  = 1'b0;

    function automatic logic [c_DW-1:0] mem_fn(input logic [c_AW-1:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5AC3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl_req"},     32'(ctl_req),         32'h0);
        chk({tag, "_ctl_refresh"}, 32'(ctl_refresh),     32'h0);
        chk({tag, "_ctl_we"},      32'(ctl_we),          32'h0);
        chk({tag, "_ctl_addr"},    32'(ctl_addr),        32'h0);
        chk({tag, "_ctl_wdata"},   32'(ctl_wdata),       32'h0);
        chk({tag, "_ctl_dm"},      32'(ctl_dm),          32'h3);
        chk({tag, "_cpu_ack"},     32'(cpu_ack),         32'h0);
        chk({tag, "_ldr_ack"},     32'(ldr_ack),         32'h0);
        chk({tag, "_cpu_rdata"},   32'(cpu_rdata),       32'h0);
        chk({tag, "_ldr_rdata"},   32'(ldr_rdata),       32'h0);
        chk({tag, "_overrun"},     32'(refresh_overrun), 32'h0);
    endtask

    // Behavioural SDRAM core: acks each command after a latency, refresh takes 2 cycles.
    initial begin : core_model
        forever begin
            @(negedge clk_48mhz);
            if (reset) begin
                ctl_ack  = 1'b0;
                core_cnt = 0;
            end else if (ctl_ack) begin
                ctl_ack = 1'b0;
            end else if (inject_ack) begin
                ctl_ack    = 1'b1;
                ctl_rdata  = 16'hDEAD;
                inject_ack = 1'b0;
            end else if (ctl_req) begin
                if (core_cnt == 0) core_cur_lat = ctl_refresh ? 2 : core_lat;
                core_cnt++;
                if (core_cnt >= core_cur_lat) begin
                    ctl_ack   = 1'b1;
                    ctl_rdata = core_force_en ? core_force_val : mem_fn(ctl_addr);
                    core_cnt  = 0;
                end
            end else begin
                core_cnt = 0;
            end
        end
    end

    initial begin : monitor
        cmd_t e;
        forever begin
            @(negedge clk_48mhz);
            if (reset) begin
                mon_prev_req = 1'b0;
            end else begin
                if (ctl_req && !mon_prev_req) begin
                    cmd_log.push_back('{ctl_refresh, ctl_addr});
                    if (!ctl_refresh) begin
                        n_tests++;
                        if (exp_cmd_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL ctl_cmd: got unexpected command addr=0x%06h we=%0b, expected none", ctl_addr, ctl_we);
                        end else begin
                            e = exp_cmd_q.pop_front();
                            if (ctl_we !== e.we || ctl_addr !== e.addr || ctl_dm !== e.dm ||
                                (e.we && ctl_wdata !== e.wdata)) begin
                                n_fail++;
                                $display("FAIL ctl_cmd: got we=%0b addr=0x%06h wdata=0x%04h dm=%b, expected we=%0b addr=0x%06h wdata=0x%04h dm=%b",
                                         ctl_we, ctl_addr, ctl_wdata, ctl_dm, e.we, e.addr, e.wdata, e.dm);
                            end
                        end
                    end
                end
                mon_prev_req = ctl_req;
                if (cpu_ack) begin
                    n_tests++;
                    if (exp_cpu_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL cpu_ack: got unexpected ack rdata=0x%04h, expected no ack", cpu_rdata);
                    end else begin
                        logic [c_DW-1:0] x;
                        x = exp_cpu_q.pop_front();
                        if (cpu_rdata !== x) begin
                            n_fail++;
                            $display("FAIL cpu_rdata: got 0x%04h, expected 0x%04h", cpu_rdata, x);
                        end
                    end
                end
                if (ldr_ack) begin
                    n_tests++;
                    if (exp_ldr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ldr_ack: got unexpected ack rdata=0x%04h, expected no ack", ldr_rdata);
                    end else begin
                        logic [c_DW-1:0] y;
                        y = exp_ldr_q.pop_front();
                        if (ldr_rdata !== y) begin
                            n_fail++;
                            $display("FAIL ldr_rdata: got 0x%04h, expected 0x%04h", ldr_rdata, y);
                        end
                    end
                end
            end
        end
    end

    task automatic expect_xfer(input logic is_ldr, input logic we, input logic [c_AW-1:0] addr,
                               input logic [c_DW-1:0] wdata, input logic [1:0] dm,
                               input logic [c_DW-1:0] rdata);
        exp_cmd_q.push_back('{we, addr, wdata, dm});
        if (is_ldr) exp_ldr_q.push_back(rdata);
        else        exp_cpu_q.push_back(rdata);
    endtask

    // Present a request and hold it until the matching ack (bounded), then release.
    task automatic xfer(input logic is_ldr, input logic we, input logic [c_AW-1:0] addr,
                        input logic [c_DW-1:0] wdata, input logic [1:0] be, input int bound);
        logic got;
        got = 1'b0;
        if (is_ldr) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_be = be;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        end
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk_48mhz);
            got = is_ldr ? ldr_ack : cpu_ack;
        end
        if (is_ldr) ldr_req = 1'b0;
        else        cpu_req = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_ack_timeout: got no ack in %0d cycles, expected an ack", is_ldr ? "ldr" : "cpu", bound);
        end
    endtask

    task automatic do_reset(input logic init_after);
        @(negedge clk_48mhz);
        reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ctl_init_done = 1'b0;
        repeat (2) @(negedge clk_48mhz);
        exp_cmd_q.delete(); exp_cpu_q.delete(); exp_ldr_q.delete(); cmd_log.delete();
        reset = 1'b0; ctl_init_done = init_after;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        vec_t tbl[6];
        int   seen;
        int   k;
        logic [c_DW-1:0] last_cpu, last_ldr;

        tbl[0] = '{1'b1, 1'b1, 24'h00A000, 16'h1234, 2'b01, 16'h7E57, 2'b10};
        tbl[1] = '{1'b0, 1'b1, 24'hFFFFFF, 16'hFFFF, 2'b11, 16'h1111, 2'b00};
        tbl[2] = '{1'b1, 1'b0, 24'h800001, 16'h0000, 2'b10, 16'h0F0F, 2'b01};
        tbl[3] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 2'b00, 16'hA5A5, 2'b11};
        tbl[4] = '{1'b1, 1'b1, 24'h123456, 16'h0000, 2'b11, 16'hC3C3, 2'b00};
        tbl[5] = '{1'b0, 1'b0, 24'h00ABCD, 16'h9999, 2'b11, 16'h8001, 2'b00};

        repeat (3) @(negedge clk_48mhz);
        check_reset_vals("rst");

        // Core not initialised: a pending CPU request must not reach the core.
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000123; cpu_wdata = '0; cpu_be = 2'b11;
        core_force_en = 1'b1; core_force_val = 16'hBEEF; core_lat = 5;
        expect_xfer(1'b0, 1'b0, 24'h000123, 16'h0, 2'b00, 16'hBEEF);
        seen = 0;
        repeat (100) begin
            @(negedge clk_48mhz);
            if (ctl_req) seen++;
        end
        chk("init_hold_ctl_req_cycles", 32'(seen), 32'd0);
        ctl_init_done = 1'b1;
        @(negedge clk_48mhz);
        chk("init_lat1_ctl_req", 32'(ctl_req), 32'h0);
        @(negedge clk_48mhz);
        chk("init_lat2_ctl_req", 32'(ctl_req), 32'h1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_48mhz);
            k++;
            if (cpu_ack) break;
        end
        chk("cpu_ack_latency", 32'(k), 32'd5);
        cpu_req = 1'b0;

        // A core ack with nothing outstanding must be ignored.
        core_force_en = 1'b0;
        repeat (3) @(negedge clk_48mhz);
        inject_ack = 1'b1;
        repeat (5) @(negedge clk_48mhz);
        chk("stray_ack_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

        core_lat = 3;
        last_cpu = cpu_rdata;
        last_ldr = ldr_rdata;
        foreach (tbl[i]) begin
            core_force_en  = 1'b1;
            core_force_val = tbl[i].core_rdata;
            expect_xfer(tbl[i].is_ldr, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_dm, tbl[i].core_rdata);
            xfer(tbl[i].is_ldr, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 40);
            if (tbl[i].is_ldr) last_ldr = tbl[i].core_rdata;
            else               last_cpu = tbl[i].core_rdata;
            repeat (2) @(negedge clk_48mhz);
        end
        core_force_en = 1'b0;
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu));
        chk("ldr_rdata_hold", 32'(ldr_rdata), 32'(last_ldr));

        // Both requesters held continuously: strict alternation starting with CPU.
        do_reset(1'b1);
        core_lat = 2;
        expect_xfer(1'b0, 1'b0, 24'h000010, 16'h0, 2'b00, mem_fn(24'h000010));
        expect_xfer(1'b1, 1'b0, 24'h000020, 16'h0, 2'b00, mem_fn(24'h000020));
        expect_xfer(1'b0, 1'b0, 24'h000011, 16'h0, 2'b00, mem_fn(24'h000011));
        expect_xfer(1'b1, 1'b0, 24'h000021, 16'h0, 2'b00, mem_fn(24'h000021));
        fork
            begin
                xfer(1'b0, 1'b0, 24'h000010, 16'h0, 2'b11, 60);
                xfer(1'b0, 1'b0, 24'h000011, 16'h0, 2'b11, 60);
            end
            begin
                xfer(1'b1, 1'b0, 24'h000020, 16'h0, 2'b11, 60);
                xfer(1'b1, 1'b0, 24'h000021, 16'h0, 2'b11, 60);
            end
        join
        repeat (4) @(negedge clk_48mhz);
        chk("rr_scoreboard_drained", 32'(exp_cmd_q.size() + exp_cpu_q.size() + exp_ldr_q.size()), 32'd0);

        // Timer expires during a long CPU transfer while the loader waits.
        do_reset(1'b1);
        core_lat = 16;
        expect_xfer(1'b0, 1'b0, 24'h000400, 16'h0, 2'b00, mem_fn(24'h000400));
        expect_xfer(1'b1, 1'b1, 24'h000800, 16'hCAFE, 2'b00, mem_fn(24'h000800));
        fork
            xfer(1'b0, 1'b0, 24'h000400, 16'h0, 2'b11, 60);
            begin
                repeat (5) @(negedge clk_48mhz);
                xfer(1'b1, 1'b1, 24'h000800, 16'hCAFE, 2'b11, 80);
            end
        join
        chk("ref_order_log_size_ge3", 32'(cmd_log.size() >= 3), 32'h1);
        if (cmd_log.size() >= 3) begin
            chk("ref_order_first_cpu",  {7'h0, cmd_log[0].refresh, cmd_log[0].addr}, {8'h0, 24'h000400});
            chk("ref_order_then_ref",   32'(cmd_log[1].refresh), 32'h1);
            chk("ref_order_then_ldr",   {7'h0, cmd_log[2].refresh, cmd_log[2].addr}, {8'h0, 24'h000800});
        end
        chk("ref_no_overrun", 32'(refresh_overrun), 32'h0);

        // Core stalls past two refresh deadlines: sticky overrun.
        do_reset(1'b1);
        core_lat = 45;
        expect_xfer(1'b0, 1'b0, 24'h000777, 16'h0, 2'b00, mem_fn(24'h000777));
        xfer(1'b0, 1'b0, 24'h000777, 16'h0, 2'b11, 80);
        chk("overrun_set", 32'(refresh_overrun), 32'h1);
        core_lat = 2;
        expect_xfer(1'b1, 1'b0, 24'h000999, 16'h0, 2'b00, mem_fn(24'h000999));
        xfer(1'b1, 1'b0, 24'h000999, 16'h0, 2'b11, 40);
        repeat (20) @(negedge clk_48mhz);
        chk("overrun_sticky", 32'(refresh_overrun), 32'h1);

        // Reset while a CPU command sits in ISSUE: dropped, no ack afterwards.
        core_lat = 30;
        exp_cmd_q.push_back('{1'b0, 24'h000555, 16'h0, 2'b00});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000555; cpu_be = 2'b11;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk_48mhz);
            if (ctl_req && !ctl_refresh) seen = 1;
        end
        chk("midissue_cmd_seen", 32'(seen), 32'h1);
        repeat (3) @(negedge clk_48mhz);
        reset = 1'b1;
        @(negedge clk_48mhz);
        check_reset_vals("midrst");
        cpu_req = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk_48mhz);

        chk("final_scoreboard_drained", 32'(exp_cmd_q.size() + exp_cpu_q.size() + exp_ldr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbitrates the single SDRAM controller port between the CPU memory bus and the UART program loader, and schedules periodic auto-refresh commands. It sits inside SoC between the two requesters and the SDRAM command core, which drives the sdram_* pins. Each requester sees a simple req/ack word interface. The block guarantees refresh priority, fair round-robin between requesters, and a sticky flag if a refresh deadline is missed.

## Interface
Parameters:
- ADDR_W, 24, word address width
- DATA_W, 16, data width (matches sdram_dq)
- REFRESH_INTERVAL, 374, cycles between refresh requests (7.8 us at 48 MHz)

Ports:
- clk_48mhz  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- cpu_req, cpu_we  in  1 each  CPU request / write enable
- cpu_addr  in  ADDR_W;  cpu_wdata  in  DATA_W;  cpu_be  in  2  byte enables
- cpu_ack  out  1  one-cycle completion pulse;  cpu_rdata  out  DATA_W
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be, ldr_ack, ldr_rdata: loader port, same shapes and directions as the CPU port
- ctl_req  out  1  command request to the SDRAM core, held until ctl_ack
- ctl_refresh  out  1  with ctl_req: auto-refresh command (addr/data don't-care)
- ctl_we  out  1;  ctl_addr  out  ADDR_W;  ctl_wdata  out  DATA_W;  ctl_dm  out  2 (ctl_dm = ~be)
- ctl_ack  in  1  core completion pulse;  ctl_rdata  in  DATA_W  valid with ctl_ack
- ctl_init_done  in  1  core has finished its power-up sequence
- refresh_overrun  out  1  sticky missed-refresh flag

## Operation
- Requester rules:
  - Hold req, we, addr, wdata and be stable until ack.
  - Deassert req, or present a new request, on the cycle after ack.
- FSM states:
  - INIT_WAIT: after reset; moves to IDLE when ctl_init_done = 1.
  - IDLE: selects a grant, loads the ctl_* registers and asserts ctl_req, then moves to ISSUE.
  - ISSUE: holds ctl_req; on ctl_ack, deasserts ctl_req, captures ctl_rdata into the granted requester's rdata, pulses its ack, and moves to DONE.
  - DONE: one cycle, then IDLE. This lets the requester drop req, so a stale req never causes a double grant.
- Grant priority in IDLE:
  1. refresh_pending
  2. Only one requester active: that requester.
  3. Both active: the one not granted last (last_grant).
- last_grant updates only on CPU/loader grants, never on refresh.
- Refresh timer:
  - Counts down from REFRESH_INTERVAL-1 and is held at reload while ctl_init_done = 0.
  - At 0: reloads and sets refresh_pending.
  - If refresh_pending is already set at that moment, refresh_overrun is set.
  - refresh_pending clears when the refresh grant is taken in IDLE.
- refresh_overrun is cleared only by reset.
- When the timer expires in the same cycle as an IDLE grant decision, the new pending bit is not yet visible. Refresh is issued at the next IDLE.
- Reads from the loader port are legal and are used for verify-after-load.

## Timing
- Reset values:
  - FSM = INIT_WAIT.
  - ctl_req, ctl_refresh, ctl_we = 0; ctl_addr, ctl_wdata = 0; ctl_dm = 2'b11.
  - cpu_ack, ldr_ack = 0; cpu_rdata, ldr_rdata = 0.
  - refresh_pending, refresh_overrun = 0; timer = REFRESH_INTERVAL-1.
  - last_grant = LDR, so the CPU wins the first tie.
- All outputs are registered.
- Latency:
  - Request visible in IDLE at cycle N gives ctl_req high at N+1.
  - ctl_ack at cycle M gives the requester ack and rdata at M+1, DONE at M+1, IDLE at M+2.
  - Back-to-back throughput: one transfer per (core latency + 3) cycles.
- ack is exactly one cycle wide. rdata holds its value until the next ack to the same port.
- Reset asserted mid-transfer: immediate return to INIT_WAIT with all outputs at reset values. The pending transfer is dropped without an ack; the SDRAM core shares this reset.
- ctl_ack outside ISSUE is ignored.

## Structure
- sdram_arb_pkg:
  - state enum {INIT_WAIT, IDLE, ISSUE, DONE}
  - grant enum {GR_CPU, GR_LDR, GR_REF}
  - default REFRESH_INTERVAL constant
- Sub-module sdram_refresh_timer:
  - Inputs: counter, enable (ctl_init_done), take (pending clear).
  - Outputs: refresh_pending, refresh_overrun.

## Test plan
- ctl_init_done low for 100 cycles with cpu_req=1 -> ctl_req stays 0. Raise init_done -> ctl_req high 2 cycles later (INIT_WAIT→IDLE, then IDLE→ISSUE).
- CPU read at addr 0x000123; core acks 5 cycles after ctl_req with rdata 0xBEEF -> ctl_addr=0x000123, ctl_we=0, one-cycle cpu_ack with cpu_rdata=0xBEEF, ldr_ack stays 0.
- Loader write at 0x00A000, wdata 0x1234, be=2'b01 -> ctl_we=1, ctl_wdata=0x1234, ctl_dm=2'b10, single ldr_ack.
- cpu_req and ldr_req held continuously after reset -> grant order CPU, LDR, CPU, LDR; no ack is ever issued twice for one request.
- REFRESH_INTERVAL=16, CPU transfer in flight when the timer expires, ldr_req waiting -> after DONE, ctl_refresh=1 is issued before the loader transfer; refresh_overrun stays 0.
- REFRESH_INTERVAL=16, core withholds ctl_ack for 40 cycles -> refresh_overrun=1 and stays 1 after traffic resumes; reset mid-ISSUE -> all outputs at reset values next cycle.
